sha256_w_window_reader: RTL and testbench
=========================================

# sha256_w_window_reader

Message-schedule reader for the second hash of the double-SHA256 pipeline. It accepts the 256-bit first-pass digest and builds the fixed second-block window: W0..W7 = digest, W8 = 0x80000000, W9..W14 = 0, W15 = 0x00000100. It then streams W_t (or W_t+K_t) for t = 0..63 to the compression round engine over a valid/ready handshake, expanding W16..W63 on the fly. It is the consumer end of the compact message-expander window path.

## Interface
- No parameters.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- load_valid  input  1  `load_block` is valid.
- load_ready  output  1  block is idle and accepts a load.
- load_block  input  256  digest; [255:224] = W0 … [31:0] = W7.
- wk_valid  output  1  `wk_data`, `round_idx` and `last` are valid.
- wk_ready  input  1  downstream accepts the current word.
- wk_data  output  32  W_t, or W_t+K_t when `SHA256_WK_PRESUM_EN` is defined.
- round_idx  output  6  t of the current word.
- last  output  1  high while t = 63 is presented.

## Operation
- States:
  - IDLE: `load_ready`=1, `wk_valid`=0.
  - RUN: `load_ready`=0, `wk_valid`=1.
- IDLE→RUN on `load_valid` high in IDLE (the load is accepted). On acceptance:
  - 16-word window win[0..15] ← {W0..W7, 0x80000000, 0×6, 0x00000100}.
  - t ← 0.
- In RUN, a word is accepted when `wk_valid` && `wk_ready`. On acceptance:
  - Window shifts down one word: win[i] ← win[i+1].
  - win[15] ← σ1(win[14]) + win[9] + σ0(win[1]) + win[0], computed mod 2^32.
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - t ← t+1.
- When t = 63 is accepted, the block returns to IDLE.
- If `wk_ready` is low, the window, t and all outputs hold. No word is skipped or duplicated.
- `load_valid` is ignored in RUN. A load is never queued.
- Words W_t for t ≥ 16 are produced once, by the shift. The window is the only storage.
- K_t comes from a 64-entry constant ROM indexed by t, holding the FIPS 180-4 constants.
- All additions are mod 2^32. Carries are discarded.

## Timing
- Reset (RST=0, asynchronous): state=IDLE, `load_ready`=1, `wk_valid`=0, `wk_data`=0, `round_idx`=0, `last`=0, window cleared.
- Reset taken mid-RUN aborts the block immediately. No partial words are emitted after release.
- Load accepted at edge N: `wk_valid`=1 with t=0 from edge N+1.
- With `wk_ready` held high:
  - One word per cycle.
  - t=63 is presented at N+64.
  - `load_ready`=1 at N+65.
- Minimum load-to-load spacing is 65 cycles.
- All outputs are driven directly from flops. There is no combinational path from `wk_ready` or `load_valid` to any output.
- `last` = (t==63) && `wk_valid`.

## Configuration
- `SHA256_WK_PRESUM_EN` defined:
  - `wk_data` = W_t + K_t. The sum is precomputed into an output register, using K_{t+1} and the next W on each accept.
  - Downstream omits the K add.
- Not defined:
  - `wk_data` = W_t.
  - The K ROM is not instantiated.
  - Timing is identical in both builds.

## Test plan
- Reset release, then load digest = 0 with `wk_ready`=1:
  - t=8 → 0x80000000.
  - t=15 → 0x00000100.
  - t=16 → 0x00000000.
  - t=17 → 0x00a00000.
  - This applies in the non-PRESUM build.
- PRESUM build, digest W0 = 0xba7816bf: t=0 → `wk_data` = 0xfd024657 (0xba7816bf + 0x428a2f98).
- Random `wk_ready` backpressure:
  - The emitted 64-word sequence must equal the sequence captured with `wk_ready`=1.
  - `wk_data` must hold stable while `wk_ready`=0.
  - `last` must be seen exactly once.
- `load_valid` pulsed at t=10 with a different block: ignored. The stream is unchanged, and `load_ready` stays 0 until t=63 is accepted.
- RST asserted at t=30: all outputs are reset values at once. After release, `load_ready`=1, and a fresh load restarts from t=0.
- Back-to-back loads with `load_valid` held high: the second load is accepted on the first IDLE cycle after t=63. There are exactly 65 cycles between accepts.

Source files
------------

// File: rtl/sha256_w_window_reader_if.sv
// Handshake bundle between the digest loader, the W-window reader and the round engine.
interface sha256_w_window_reader_if;
  logic         load_valid;
  logic         load_ready;
  logic [255:0] load_block;
  logic         wk_valid;
  logic         wk_ready;
  logic [31:0]  wk_data;
  logic [5:0]   round_idx;
  logic         last;

  modport master (
    output load_valid, load_block, wk_ready,
    input  load_ready, wk_valid, wk_data, round_idx, last
  );

  modport slave (
    input  load_valid, load_block, wk_ready,
    output load_ready, wk_valid, wk_data, round_idx, last
  );
endinterface

// File: rtl/sha256_w_window_reader.sv
// Second-pass SHA-256 message schedule reader: 16-word sliding window, one W_t per accept.
// Define SHA256_WK_PRESUM_EN to emit W_t+K_t from a registered presum instead of W_t.
module sha256_w_window_reader (
  input  logic                           CLK,
  input  logic                           RST,
  sha256_w_window_reader_if.slave        bus
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q, state_d;
  logic [31:0]  win_q [16];
  logic [31:0]  win_d [16];
  logic [5:0]   t_q, t_d;
  logic         load_ready_q, load_ready_d;
  logic         wk_valid_q, wk_valid_d;
  logic         last_q, last_d;
  logic [31:0]  wk_data_q, wk_data_d;
  logic [31:0]  w_new;
  logic [31:0]  k_first;
  logic [31:0]  k_next;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Second block of double-SHA256 is always digest + fixed padding for a 256-bit message.
  function automatic logic [31:0] init_word(input logic [255:0] blk, input int idx);
    logic [31:0] w;
    if (idx < 8)       w = blk[255 - 32*idx -: 32];
    else if (idx == 8) w = 32'h8000_0000;
    else if (idx == 15) w = 32'h0000_0100;
    else               w = 32'h0000_0000;
    return w;
  endfunction

`ifdef SHA256_WK_PRESUM_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  // The registered output is loaded with the sum for the word that becomes visible next.
  assign k_first = K_ROM[6'd0];
  assign k_next  = K_ROM[t_q + 6'd1];
`else
  assign k_first = 32'h0000_0000;
  assign k_next  = 32'h0000_0000;
`endif

  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    t_d          = t_q;
    load_ready_d = load_ready_q;
    wk_valid_d   = wk_valid_q;
    last_d       = last_q;
    wk_data_d    = wk_data_q;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          state_d      = RUN;
          load_ready_d = 1'b0;
          wk_valid_d   = 1'b1;
          last_d       = 1'b0;
          t_d          = 6'd0;
          for (int i = 0; i < 16; i++) win_d[i] = init_word(bus.load_block, i);
          wk_data_d    = bus.load_block[255:224] + k_first;
        end
      end
      RUN: begin
        if (bus.wk_ready) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = w_new;
          t_d       = t_q + 6'd1;
          wk_data_d = win_q[1] + k_next;
          if (t_q == 6'd63) begin
            state_d      = IDLE;
            load_ready_d = 1'b1;
            wk_valid_d   = 1'b0;
            last_d       = 1'b0;
          end else begin
            last_d = (t_q == 6'd62);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      t_q          <= 6'd0;
      load_ready_q <= 1'b1;
      wk_valid_q   <= 1'b0;
      last_q       <= 1'b0;
      wk_data_q    <= 32'h0000_0000;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      load_ready_q <= load_ready_d;
      wk_valid_q   <= wk_valid_d;
      last_q       <= last_d;
      wk_data_q    <= wk_data_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.wk_valid   = wk_valid_q;
  assign bus.wk_data    = wk_data_q;
  assign bus.round_idx  = t_q;
  assign bus.last       = last_q;
endmodule

// File: tb/tb_sha256_w_window_reader.sv
// Scoreboard bench for sha256_w_window_reader: expected streams come from a plain SHA-256
// schedule model; a negedge monitor pops and compares every accepted word.
`timescale 1ns/1ps
module tb_sha256_w_window_reader;
  logic CLK = 1'b0;
  logic RST = 1'b0;

  sha256_w_window_reader_if bus();

  sha256_w_window_reader dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned accepts[$];
  logic [31:0] cap [64];
  int          last_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          held_valid = 1'b0;
  logic [31:0] held_data;
  logic [5:0]  held_idx;

`ifdef SHA256_WK_PRESUM_EN
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full 64-word schedule built the textbook way, then queued as the expected stream.
  function automatic void push_block(input logic [255:0] blk);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 8; t++) w[t] = blk[255 - 32*t -: 32];
    w[8] = 32'h8000_0000;
    for (int t = 9; t < 15; t++) w[t] = 32'h0;
    w[15] = 32'h0000_0100;
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) begin
`ifdef SHA256_WK_PRESUM_EN
      e.data = w[t] + KT[t];
`else
      e.data = w[t];
`endif
      e.idx  = 6'(t);
      e.last = (t == 63);
      sb.push_back(e);
    end
  endfunction

  function automatic logic [255:0] rand_block();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST && bus.load_valid && bus.load_ready) accepts.push_back(cyc);
  end

  // Monitor: compares accepted words with the scoreboard and checks hold under backpressure.
  always @(negedge CLK) begin
    if (!RST) begin
      held_valid = 1'b0;
    end else if (bus.wk_valid) begin
      check("load_ready_busy", 64'(bus.load_ready), 64'd0);
      if (held_valid) begin
        check("hold_data", 64'(bus.wk_data), 64'(held_data));
        check("hold_idx", 64'(bus.round_idx), 64'(held_idx));
      end
      if (bus.wk_ready) begin
        held_valid = 1'b0;
        cap[bus.round_idx] = bus.wk_data;
        if (bus.last) last_cnt++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got t=%0d data %0h, required no word", bus.round_idx, bus.wk_data);
        end else begin
          mon_e = sb.pop_front();
          check("wk_data", 64'(bus.wk_data), 64'(mon_e.data));
          check("round_idx", 64'(bus.round_idx), 64'(mon_e.idx));
          check("last", 64'(bus.last), 64'(mon_e.last));
        end
      end else begin
        held_valid = 1'b1;
        held_data  = bus.wk_data;
        held_idx   = bus.round_idx;
      end
    end
  end

  initial begin
    bus.wk_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      bus.wk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_load(input logic [255:0] blk);
    int n = 0;
    while (!bus.load_ready && n < 300) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("load_ready_before_load", 64'(bus.load_ready), 64'd1);
    push_block(blk);
    bus.load_valid = 1'b1;
    bus.load_block = blk;
    @(posedge CLK);
    #1;
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d words outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge CLK);
    #1;
    check("idle_load_ready", 64'(bus.load_ready), 64'd1);
    check("idle_wk_valid", 64'(bus.wk_valid), 64'd0);
  endtask

  task automatic wait_round(input logic [5:0] t);
    int n = 0;
    while (!(bus.wk_valid && bus.round_idx == t) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check("reach_round", 64'(bus.round_idx), 64'(t));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, 64'(bus.load_ready), 64'd1);
    check({tag, "_wk_valid"}, 64'(bus.wk_valid), 64'd0);
    check({tag, "_wk_data"}, 64'(bus.wk_data), 64'd0);
    check({tag, "_round_idx"}, 64'(bus.round_idx), 64'd0);
    check({tag, "_last"}, 64'(bus.last), 64'd0);
  endtask

  initial begin
    logic [255:0] blk_a;
    logic [255:0] blk_b;
    int n0;
    int n;
    bus.load_valid = 1'b0;
    bus.load_block = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

`ifdef SHA256_WK_PRESUM_EN
    blk_a = rand_block();
    blk_a[255:224] = 32'hba7816bf;
    do_load(blk_a);
    wait_drain(200);
    check("presum_t0", 64'(cap[0]), 64'hfd024657);
`else
    do_load('0);
    wait_drain(200);
    check("zero_t8", 64'(cap[8]), 64'h8000_0000);
    check("zero_t15", 64'(cap[15]), 64'h0000_0100);
    check("zero_t16", 64'(cap[16]), 64'h0000_0000);
    check("zero_t17", 64'(cap[17]), 64'h00a0_0000);
`endif

    // Random digests under random backpressure.
    rand_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      last_cnt = 0;
      do_load(rand_block());
      wait_drain(1500);
      check("last_once", 64'(last_cnt), 64'd1);
    end

    // A load offered mid-stream must be dropped, not queued.
    rand_ready = 1'b0;
    blk_a = rand_block();
    blk_b = rand_block();
    do_load(blk_a);
    wait_round(6'd10);
    n0 = accepts.size();
    bus.load_valid = 1'b1;
    bus.load_block = blk_b;
    @(posedge CLK);
    #1;
    bus.load_valid = 1'b0;
    wait_drain(200);
    check("midrun_load_ignored", 64'(accepts.size()), 64'(n0));

    // Asynchronous reset in the middle of a stream.
    rand_ready = 1'b1;
    do_load(rand_block());
    wait_round(6'd30);
    #2;
    RST = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    sb.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("post_reset_load_ready", 64'(bus.load_ready), 64'd1);
    check("post_reset_wk_valid", 64'(bus.wk_valid), 64'd0);
    do_load(rand_block());
    wait_drain(1500);

    // Back-to-back loads with load_valid held high.
    rand_ready = 1'b0;
    @(posedge CLK);
    #1;
    blk_a = rand_block();
    blk_b = rand_block();
    n0 = accepts.size();
    push_block(blk_a);
    push_block(blk_b);
    bus.load_valid = 1'b1;
    bus.load_block = blk_a;
    n = 0;
    while (accepts.size() < n0 + 1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    #1;
    bus.load_block = blk_b;
    n = 0;
    while (accepts.size() < n0 + 2 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    #1;
    bus.load_valid = 1'b0;
    if (accepts.size() >= n0 + 2)
      check("load_spacing", 64'(accepts[n0+1] - accepts[n0]), 64'd65);
    else begin
      vectors++;
      miscompares++;
      $display("FAIL back_to_back: got %0d accepts, required 2", accepts.size() - n0);
    end
    wait_drain(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
